// File: rtl/lbm_pkg.sv
// Shared types and constants for the D2Q9 macroscopic-moment datapath.
package lbm_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int FRAC_BITS  = 24;

  typedef logic signed [DATA_WIDTH-1:0] fixed_t;

  localparam fixed_t FIXED_MAX = 32'h7FFFFFFF;
  localparam fixed_t FIXED_MIN = 32'h80000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/lbm_velocity_div_udiv_seq.sv
// Bit-serial unsigned restoring divider datapath; sequencing is owned by the caller.
module udiv_seq #(
  parameter int N  = 56,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          load,
  input  logic          step,
  input  logic [N-1:0]  dividend,
  input  logic [DW-1:0] divisor,
  output logic [N-1:0]  quotient
);
  logic [N-1:0]  dvd;
  logic [DW-1:0] dsr;
  logic [DW-1:0] rem;
  logic [DW:0]   rem_shift;
  logic [DW:0]   trial;
  logic          fits;

  // Partial remainder stays below the divisor, so DW+1 bits always hold the shifted value.
  always_comb begin
    rem_shift = {rem, dvd[N-1]};
    trial     = rem_shift - {1'b0, dsr};
    fits      = (rem_shift >= {1'b0, dsr});
  end

  always_ff @(posedge clk) begin
    if (load) begin
      dvd      <= dividend;
      dsr      <= divisor;
      rem      <= '0;
      quotient <= '0;
    end else if (step) begin
      dvd      <= {dvd[N-2:0], 1'b0};
      rem      <= fits ? trial[DW-1:0] : rem_shift[DW-1:0];
      quotient <= {quotient[N-2:0], fits};
    end
  end
endmodule

// File: rtl/lbm_velocity_div.sv
// Velocity ux = mx/rho, uy = my/rho in Q8.24 via two shared-control serial dividers.
module lbm_velocity_div
  import lbm_pkg::*;
(
  input  logic   Clk,
  input  logic   Reset,
  input  logic   in_valid,
  output logic   in_ready,
  input  fixed_t rho,
  input  fixed_t mx,
  input  fixed_t my,
  output logic   out_valid,
  input  logic   out_ready,
  output fixed_t ux,
  output fixed_t uy,
  output logic   div_zero
);
  localparam int N     = DATA_WIDTH + FRAC_BITS;
  localparam int CNT_W = $clog2(N);

  div_state_t       state, state_next;
  logic [CNT_W-1:0] counter;
  logic             accept, load, step;
  logic             sign_x, sign_y;
  logic [N-1:0]     qx, qy;

  function automatic logic [DATA_WIDTH-1:0] mag(input fixed_t v);
    return v[DATA_WIDTH-1] ? (~v) + fixed_t'(1) : v;
  endfunction

  // Quotients beyond the Q8.24 range clamp to the signed extremes.
  function automatic fixed_t saturate(input logic [N-1:0] q, input logic neg);
    if (|q[N-1:DATA_WIDTH-1])
      return neg ? FIXED_MIN : FIXED_MAX;
    return neg ? -fixed_t'(q[DATA_WIDTH-1:0]) : fixed_t'(q[DATA_WIDTH-1:0]);
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = (rho == '0) ? DONE : CALC;
      CALC: if (counter == '0) state_next = DONE;
      DONE: if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && !Reset;
    accept   = in_valid && in_ready;
    load     = accept;
    step     = (state == CALC);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      counter   <= '0;
      sign_x    <= 1'b0;
      sign_y    <= 1'b0;
      out_valid <= 1'b0;
      ux        <= '0;
      uy        <= '0;
      div_zero  <= 1'b0;
    end else begin
      if (accept) begin
        counter  <= CNT_W'(N - 1);
        sign_x   <= mx[DATA_WIDTH-1] ^ rho[DATA_WIDTH-1];
        sign_y   <= my[DATA_WIDTH-1] ^ rho[DATA_WIDTH-1];
        div_zero <= (rho == '0);
      end else if (step && counter != '0) begin
        counter <= counter - 1'b1;
      end
      // First DONE cycle registers the final result; it then holds until consumed.
      if (state == DONE && !out_valid) begin
        out_valid <= 1'b1;
        ux        <= div_zero ? '0 : saturate(qx, sign_x);
        uy        <= div_zero ? '0 : saturate(qy, sign_y);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  udiv_seq #(.N(N), .DW(DATA_WIDTH)) u_div_x (
    .clk      (Clk),
    .load     (load),
    .step     (step),
    .dividend ({mag(mx), {FRAC_BITS{1'b0}}}),
    .divisor  (mag(rho)),
    .quotient (qx)
  );

  udiv_seq #(.N(N), .DW(DATA_WIDTH)) u_div_y (
    .clk      (Clk),
    .load     (load),
    .step     (step),
    .dividend ({mag(my), {FRAC_BITS{1'b0}}}),
    .divisor  (mag(rho)),
    .quotient (qy)
  );
endmodule
